rv32i_div_unit: RTL and testbench



---
 rtl/rv32i_div_unit.sv | 167 ++++++++++++++++
 tb/tb_rv32i_div_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_div_unit.sv
// rtl/rv32i_div_unit.sv - iterative radix-2 RV32M divide/remainder unit; optional DIV_REM_REUSE_EN result reuse
module rv32i_div_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  flush,
    output logic                  busy,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]       wb_data
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    state_t                  state;
    logic [4:0]              count;
    logic [XLEN-1:0]         quo_q;
    logic [XLEN-1:0]         rem_q;
    logic [XLEN-1:0]         divisor_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic                    op_rem_q;
    logic                    neg_q;
    logic                    neg_r;

    // Operand conditioning in IDLE; op[0]=1 selects the unsigned variants
    logic                    in_signed, rs1_neg, rs2_neg, div_zero, overflow, special;
    logic [XLEN-1:0]         abs1, abs2, special_res;

    assign in_signed   = ~op[0];
    assign rs1_neg     = in_signed & rs1_data[XLEN-1];
    assign rs2_neg     = in_signed & rs2_data[XLEN-1];
    assign abs1        = rs1_neg ? -rs1_data : rs1_data;
    assign abs2        = rs2_neg ? -rs2_data : rs2_data;
    assign div_zero    = (rs2_data == '0);
    assign overflow    = in_signed && (rs1_data == SMIN) && (rs2_data == ONES);
    assign special     = div_zero || overflow;
    assign special_res = div_zero ? (op[1] ? rs1_data : ONES) : (op[1] ? '0 : SMIN);

    // One restoring step; bit XLEN of the trial difference is the borrow
    logic [XLEN:0]           trial;
    logic [XLEN-1:0]         quo_next, rem_next, q_res, r_res;

    assign trial    = {rem_q, quo_q[XLEN-1]} - {1'b0, divisor_q};
    assign rem_next = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
    assign quo_next = {quo_q[XLEN-2:0], ~trial[XLEN]};
    assign q_res    = neg_q ? -quo_next : quo_next;
    assign r_res    = neg_r ? -rem_next : rem_next;

    logic                    reuse_hit;
    logic [XLEN-1:0]         reuse_res;

`ifdef DIV_REM_REUSE_EN
    logic                    ent_valid;
    logic                    ent_signed;
    logic [XLEN-1:0]         ent_rs1, ent_rs2, ent_quo, ent_rem;

    assign reuse_hit = ent_valid && (ent_rs1 == rs1_data) && (ent_rs2 == rs2_data)
                       && (ent_signed == in_signed);
    assign reuse_res = op[1] ? ent_rem : ent_quo;

    // Key is captured at launch but only marked valid once the full calculation lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid  <= 1'b0;
            ent_signed <= 1'b0;
            ent_rs1    <= '0;
            ent_rs2    <= '0;
            ent_quo    <= '0;
            ent_rem    <= '0;
        end else if (flush) begin
            ent_valid <= 1'b0;
        end else if (state == IDLE && start) begin
            if (special) begin
                ent_valid <= 1'b0;
            end else if (!reuse_hit) begin
                ent_valid  <= 1'b0;
                ent_signed <= in_signed;
                ent_rs1    <= rs1_data;
                ent_rs2    <= rs2_data;
            end
        end else if (state == CALC && count == 5'd31) begin
            ent_valid <= 1'b1;
            ent_quo   <= q_res;
            ent_rem   <= r_res;
        end
    end
`else
    assign reuse_hit = 1'b0;
    assign reuse_res = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            rd_q      <= '0;
            op_rem_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        rd_q     <= rd_addr;
                        op_rem_q <= op[1];
                        busy     <= 1'b1;
                        if (special || reuse_hit) begin
                            state    <= DONE;
                            wb_valid <= (rd_addr != '0);
                            wb_addr  <= rd_addr;
                            wb_data  <= special ? special_res : reuse_res;
                        end else begin
                            state     <= CALC;
                            count     <= '0;
                            quo_q     <= abs1;
                            rem_q     <= '0;
                            divisor_q <= abs2;
                            neg_q     <= rs1_neg ^ rs2_neg;
                            neg_r     <= rs1_neg;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        quo_q <= quo_next;
                        rem_q <= rem_next;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state    <= DONE;
                            wb_valid <= (rd_q != '0);
                            wb_addr  <= rd_q;
                            wb_data  <= op_rem_q ? r_res : q_res;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_div_unit.sv
// tb/tb_rv32i_div_unit.sv - scoreboard bench for rv32i_div_unit with randomized ops
module tb_rv32i_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        busy, wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    rv32i_div_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .rd_addr(rd_addr), .flush(flush), .busy(busy),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t scb[$];

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: language-level division with the RV32M corner-case rules
    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sbv;
        sa = a;
        sbv = b;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            2'd0:    return sa / sbv;
            2'd1:    return a / b;
            2'd2:    return sa % sbv;
            default: return a % b;
        endcase
    endfunction

    // Model of the reuse store: last fully computed operand pair
    bit          m_valid = 0;
    logic [31:0] m_a, m_b;
    bit          m_signed;

    function automatic int model_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (is_special(o, a, b)) begin
            m_valid = 0;
            return 0;
        end
`ifdef DIV_REM_REUSE_EN
        if (m_valid && m_a == a && m_b == b && m_signed == !o[0]) return 0;
`endif
        m_valid  = 1;
        m_a      = a;
        m_b      = b;
        m_signed = !o[0];
        return 32;
    endfunction

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (scb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_wb: got addr %0d data %h expected no write", wb_addr, wb_data);
            end else begin
                exp_t e;
                e = scb.pop_front();
                check("wb_addr", {27'b0, wb_addr}, {27'b0, e.addr});
                check("wb_data", wb_data, e.data);
                check("wb_cycle", cyc, e.at);
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit spam);
        int lat, bcnt;
        exp_t e;
        @(negedge clk);
        start = 1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
        lat = model_latency(o, a, b);
        if (rd != 0) begin
            e.addr = rd;
            e.data = ref_div(o, a, b);
            e.at   = cyc + 1 + lat;
            scb.push_back(e);
        end
        @(posedge clk);
        #1 start = 0;
        bcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                start = 0;
                break;
            end
            bcnt++;
            if (spam) begin
                start    = 1'($urandom_range(0, 1));
                op       = 2'($urandom);
                rs1_data = $urandom;
                rs2_data = $urandom;
                rd_addr  = 5'($urandom_range(1, 31));
            end
        end
        start = 0;
        check("busy_cycles", bcnt, lat + 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        rst = 1; start = 0; op = 0; rs1_data = 0; rs2_data = 0; rd_addr = 0; flush = 0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_wb_valid", {31'b0, wb_valid}, 0);
        check("reset_wb_addr", {27'b0, wb_addr}, 0);
        check("reset_wb_data", wb_data, 0);
        rst = 0;

        do_op(2'd1, 100, 7, 5, 0);
        do_op(2'd3, 100, 7, 5, 0);
        do_op(2'd0, 32'hFFFF_FFF9, 2, 6, 1);
        do_op(2'd2, 32'hFFFF_FFF9, 2, 7, 0);
        do_op(2'd1, 5, 0, 8, 0);
        do_op(2'd2, 5, 0, 9, 0);
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 11, 0);
        do_op(2'd0, 1000, 3, 12, 0);
        do_op(2'd2, 1000, 3, 13, 1);
        do_op(2'd1, 12345, 67, 0, 0);

        // start coinciding with flush in IDLE is dropped
        @(negedge clk);
        start = 1; flush = 1; op = 2'd0; rs1_data = 77; rs2_data = 5; rd_addr = 3;
        @(posedge clk);
        #1 start = 0; flush = 0;
        m_valid = 0;
        @(negedge clk);
        check("flush_idle_busy", {31'b0, busy}, 0);

        // flush mid-calculation aborts without a write
        @(negedge clk);
        start = 1; op = 2'd0; rs1_data = 32'hDEAD_BEEF; rs2_data = 13; rd_addr = 4;
        @(posedge clk);
        #1 start = 0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        m_valid = 0;
        @(negedge clk);
        check("flush_calc_busy", {31'b0, busy}, 0);
        do_op(2'd0, 32'hDEAD_BEEF, 13, 4, 0);

        // asynchronous reset mid-calculation
        @(negedge clk);
        start = 1; op = 2'd1; rs1_data = 999; rs2_data = 10; rd_addr = 14;
        @(posedge clk);
        #1 start = 0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1;
        m_valid = 0;
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_wb_valid", {31'b0, wb_valid}, 0);
        check("rst_wb_addr", {27'b0, wb_addr}, 0);
        check("rst_wb_data", wb_data, 0);
        @(negedge clk);
        rst = 0;

        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom);
            a = pick();
            b = pick();
            do_op(o, a, b, 5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) do_op(o ^ 2'b10, a, b, 5'($urandom_range(1, 31)), 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", scb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
